// File: rtl/handshake_rr_merge.sv
// handshake_rr_merge
// Merges N upstream req/ack sources onto one downstream req/ack consumer.
// Sources are picked round-robin from a rotating pointer. Each forwarded word
// carries the index of the source that supplied it. A source that does not ack
// within TIMEOUT cycles is skipped, so a stalled source cannot hold the shared
// consumer forever.

module handshake_rr_merge #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_W      = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            src_en,
  output logic [N-1:0]            up_req,
  input  logic [N-1:0]            up_ack,
  input  logic [N*DATA_WIDTH-1:0] up_din,
  input  logic                    dn_req,
  output logic                    dn_ack,
  output logic [DATA_WIDTH-1:0]   dn_dout,
  output logic [SRC_W-1:0]        dn_src,
  output logic                    busy,
  output logic [15:0]             timeout_cnt
);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t           state;
  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] sel;
  logic [15:0]      wait_cnt;

  logic [SRC_W-1:0] scan_sel;
  logic             scan_hit;
  logic [SRC_W:0]   scan_idx;
  logic [SRC_W-1:0] sel_next;
  logic             timeout_hit;

  // Find the first enabled source starting at ptr and wrapping modulo N.
  // The index is one bit wider so the wrap works for any N, not only powers of 2.
  always_comb begin
    scan_sel = '0;
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr} + (SRC_W+1)'(k);
      if (scan_idx >= (SRC_W+1)'(N)) begin
        scan_idx = scan_idx - (SRC_W+1)'(N);
      end
      if (!scan_hit && src_en[scan_idx[SRC_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_sel = scan_idx[SRC_W-1:0];
      end
    end
  end

  // The pointer moves past the source just finished, wrapping from N-1 to 0.
  assign sel_next = (sel == SRC_W'(N-1)) ? '0 : sel + 1'b1;

  // The last waiting cycle of a request; never true when TIMEOUT is zero.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 16'(TIMEOUT - 1));

  // Two-state arbiter: IDLE picks a source, REQ holds its request until
  // it acks or the wait budget runs out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      sel         <= '0;
      wait_cnt    <= '0;
      up_req      <= '0;
      dn_ack      <= 1'b0;
      dn_dout     <= '0;
      dn_src      <= '0;
      busy        <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          dn_ack <= 1'b0;
          if (dn_req && !dn_ack && scan_hit) begin
            sel      <= scan_sel;
            up_req   <= {{(N-1){1'b0}}, 1'b1} << scan_sel;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (up_ack[sel]) begin
            up_req  <= '0;
            dn_dout <= up_din[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            dn_src  <= sel;
            dn_ack  <= 1'b1;
            ptr     <= sel_next;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (timeout_hit) begin
            up_req <= '0;
            ptr    <= sel_next;
            busy   <= 1'b0;
            state  <= IDLE;
            if (timeout_cnt != 16'hFFFF) begin
              timeout_cnt <= timeout_cnt + 16'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
